// File: rtl/i2c_master_wb_if.sv
// Wishbone register-bus bundle for the I2C master.
//   wb_adr_i  : register address (3 bits)
//   wb_dat_i  : write data (8 bits)
//   wb_dat_o  : registered read data (8 bits)
//   wb_we_i   : 1 = write, 0 = read
//   wb_stb_i  : strobe
//   wb_cyc_i  : bus cycle
//   wb_ack_o  : single-cycle acknowledge
//   wb_inta_o : interrupt request
// master modport = CPU/bus side, slave modport = the I2C master core.
interface i2c_master_wb_if;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_cyc_i;
  logic       wb_ack_o;
  logic       wb_inta_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_inta_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_inta_o
  );
endinterface

// File: rtl/i2c_master_wb.sv
// Wishbone-slave I2C master: generates START, STOP, byte write and byte read
// (with ACK/NACK) on open-drain SCL/SDA pads.
// Ports:
//   wb_clk_i      system clock
//   arst_i        asynchronous reset, active-low
//   wb_rst_i      synchronous reset, active-high
//   wb            Wishbone register bus (i2c_master_wb_if.slave)
//   scl_pad_i     sampled SCL line
//   scl_pad_o     SCL drive value, constant 0
//   scl_padoen_o  SCL output enable, active-low (1 = released)
//   sda_pad_i     sampled SDA line
//   sda_pad_o     SDA drive value, constant 0
//   sda_padoen_o  SDA output enable, active-low (1 = released)
// Register map: 0 PRER, 1 CTR{EN,IEN}, 2 TXR(w)/RXR(r), 3 CR(w)/SR(r).
// Build option: define I2C_CLK_STRETCH_EN to hold the phase counter while a
// released SCL still reads low (slave clock stretching).
module i2c_master_wb (
  input  logic           wb_clk_i,
  input  logic           arst_i,
  input  logic           wb_rst_i,
  i2c_master_wb_if.slave wb,
  input  logic           scl_pad_i,
  output logic           scl_pad_o,
  output logic           scl_padoen_o,
  input  logic           sda_pad_i,
  output logic           sda_pad_o,
  output logic           sda_padoen_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_e;

  state_e     state;
  logic [7:0] prer, txr, rxr, sh, cnt, rd_mux;
  logic       ctr_en, ctr_ien;
  logic       cr_sta, cr_sto, cr_rd, cr_wr, cr_ack;
  logic       sr_rxack, sr_busy, sr_tip, sr_if;
  logic [1:0] phase;
  logic [3:0] bit_cnt;
  logic       sda_s;
  logic       stall, tick, last_phase, wr_acc, cmd_ok, fin;
  logic       scl_nxt, sda_nxt, d_bit;

  assign scl_pad_o = 1'b0;
  assign sda_pad_o = 1'b0;

`ifdef I2C_CLK_STRETCH_EN
  assign stall = scl_padoen_o & ~scl_pad_i;
`else
  logic unused_scl;
  assign unused_scl = scl_pad_i;
  assign stall      = 1'b0;
`endif

  assign tick       = (cnt == prer) & ~stall;
  assign last_phase = tick & (phase == 2'd3);
  assign wr_acc     = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i & wb.wb_ack_o;
  assign cmd_ok     = ctr_en & (state == S_IDLE) & ~sr_tip;

  // Command completes at the end of its final bit; otherwise the FSM chains on.
  assign fin = last_phase & (
                 ((state == S_START) & ~(cr_rd | cr_wr) & ~cr_sto) |
                 ((state == S_BIT) & (bit_cnt == 4'd8) & ~cr_sto) |
                 (state == S_STOP));

  // SDA level for the current data bit; the 9th bit is the acknowledge slot.
  always_comb begin
    if (bit_cnt == 4'd8) d_bit = cr_wr ? 1'b1 : cr_ack;
    else                 d_bit = cr_wr ? sh[7] : 1'b1;
  end

  always_comb begin
    scl_nxt = 1'b1;
    sda_nxt = 1'b1;
    case (state)
      S_START: begin scl_nxt = (phase != 2'd3); sda_nxt = (phase < 2'd2); end
      S_STOP:  begin scl_nxt = (phase != 2'd0); sda_nxt = (phase >= 2'd2); end
      S_BIT:   begin scl_nxt = (phase == 2'd1) | (phase == 2'd2); sda_nxt = d_bit; end
      default: ;
    endcase
  end

  always_comb begin
    case (wb.wb_adr_i)
      3'd0:    rd_mux = prer;
      3'd1:    rd_mux = {ctr_en, ctr_ien, 6'b0};
      3'd2:    rd_mux = rxr;
      3'd3:    rd_mux = {sr_rxack, sr_busy, 4'b0, sr_tip, sr_if};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wb.wb_ack_o <= 1'b0; wb.wb_dat_o <= '0; wb.wb_inta_o <= 1'b0;
      prer <= '0; txr <= '0; rxr <= '0; sh <= '0; cnt <= '0;
      ctr_en <= 1'b0; ctr_ien <= 1'b0;
      {cr_sta, cr_sto, cr_rd, cr_wr, cr_ack} <= '0;
      {sr_rxack, sr_busy, sr_tip, sr_if} <= '0;
      phase <= '0; bit_cnt <= '0; sda_s <= 1'b0; state <= S_IDLE;
      scl_padoen_o <= 1'b1; sda_padoen_o <= 1'b1;
    end else if (wb_rst_i) begin
      wb.wb_ack_o <= 1'b0; wb.wb_dat_o <= '0; wb.wb_inta_o <= 1'b0;
      prer <= '0; txr <= '0; rxr <= '0; sh <= '0; cnt <= '0;
      ctr_en <= 1'b0; ctr_ien <= 1'b0;
      {cr_sta, cr_sto, cr_rd, cr_wr, cr_ack} <= '0;
      {sr_rxack, sr_busy, sr_tip, sr_if} <= '0;
      phase <= '0; bit_cnt <= '0; sda_s <= 1'b0; state <= S_IDLE;
      scl_padoen_o <= 1'b1; sda_padoen_o <= 1'b1;
    end else begin
      wb.wb_ack_o  <= wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
      wb.wb_inta_o <= ctr_ien & sr_if;
      if (wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o) wb.wb_dat_o <= rd_mux;

      if (wr_acc) begin
        case (wb.wb_adr_i)
          3'd0: prer <= wb.wb_dat_i;
          3'd1: begin ctr_en <= wb.wb_dat_i[7]; ctr_ien <= wb.wb_dat_i[6]; end
          3'd2: txr <= wb.wb_dat_i;
          3'd3: begin
            if (wb.wb_dat_i[0]) sr_if <= 1'b0;
            if (cmd_ok && (wb.wb_dat_i[7:4] != 4'b0)) begin
              {cr_sta, cr_sto, cr_rd, cr_wr} <= wb.wb_dat_i[7:4];
              cr_ack <= wb.wb_dat_i[3];
              sr_tip <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (!ctr_en) begin
        state <= S_IDLE; sr_tip <= 1'b0; cnt <= '0; phase <= '0;
        scl_padoen_o <= 1'b1; sda_padoen_o <= 1'b1;
      end else begin
        // Pads follow the phase one clock later; in IDLE they hold their last
        // level so SCL stays low between chained bytes.
        if (state != S_IDLE) begin
          {scl_padoen_o, sda_padoen_o} <= {scl_nxt, sda_nxt};
          if (tick) cnt <= '0;
          else if (!stall) cnt <= cnt + 8'd1;
          if (tick) phase <= phase + 2'd1;
          if (tick && phase == 2'd2) sda_s <= sda_pad_i;
        end
        case (state)
          S_IDLE: if (sr_tip) begin
            cnt <= '0; phase <= '0; bit_cnt <= '0; sh <= txr;
            if (cr_sta)              state <= S_START;
            else if (cr_rd | cr_wr)  state <= S_BIT;
            else                     state <= S_STOP;
          end
          S_START: if (last_phase) begin
            sr_busy <= 1'b1;
            if (cr_rd | cr_wr)  state <= S_BIT;
            else if (cr_sto)    state <= S_STOP;
          end
          S_BIT: if (last_phase) begin
            sh      <= {sh[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd8) begin
              if (cr_wr) sr_rxack <= sda_s;
              else       rxr      <= sh;
              if (cr_sto) state <= S_STOP;
            end
          end
          S_STOP: if (last_phase) sr_busy <= 1'b0;
          default: state <= S_IDLE;
        endcase
        if (fin) begin
          state  <= S_IDLE;
          sr_tip <= 1'b0;
          sr_if  <= 1'b1;
          {cr_sta, cr_sto, cr_rd, cr_wr} <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_wb.sv
// Directed self-checking bench for i2c_master_wb with a small I2C slave model.
module tb_i2c_master_wb;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic wb_rst = 1'b0;
  logic scl_o, scl_oen, sda_o, sda_oen;
  logic scl_line, sda_line;
  logic sda_slave = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // slave model controls and line monitor state
  logic       slave_rd = 1'b0;
  logic       ack_val = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         rise_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic       line_bits [0:15];
  logic       oen9 = 1'b0;
  int unsigned cyc_n = 0, t1 = 0, t2 = 0;

  i2c_master_wb_if bus();

  i2c_master_wb dut (
    .wb_clk_i     (clk),
    .arst_i       (arst_n),
    .wb_rst_i     (wb_rst),
    .wb           (bus.slave),
    .scl_pad_i    (scl_line),
    .scl_pad_o    (scl_o),
    .scl_padoen_o (scl_oen),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_o),
    .sda_padoen_o (sda_oen)
  );

  assign scl_line = scl_oen;
  assign sda_line = sda_oen & sda_slave;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  always @(posedge scl_line) begin
    rise_cnt++;
    if (rise_cnt < 16) line_bits[rise_cnt] = sda_line;
    if (rise_cnt == 1) t1 = cyc_n;
    if (rise_cnt == 2) t2 = cyc_n;
    if (rise_cnt == 9) oen9 = sda_oen;
  end

  always @(negedge scl_line) begin
    if (slave_rd) sda_slave = (rise_cnt < 8) ? rd_byte[7 - rise_cnt] : 1'b1;
    else          sda_slave = (rise_cnt == 8) ? ack_val : 1'b1;
  end

  always @(negedge sda_line) if (scl_line === 1'b1) start_cnt++;
  always @(posedge sda_line) if (scl_line === 1'b1) stop_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = 1'b1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.wb_adr_i = a; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    d = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] s;
    int unsigned k;
    k = 0;
    do begin
      wb_rd(3'd3, s);
      k++;
    end while (s[1] && k < 3000);
    check({tag, "_tip_clear"}, s[1], 1'b0);
  endtask

  task automatic clr_mon();
    rise_cnt = 0; start_cnt = 0; stop_cnt = 0; oen9 = 1'b0;
    for (int i = 0; i < 16; i++) line_bits[i] = 1'bx;
  endtask

  function automatic logic [7:0] line_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = line_bits[i + 1];
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk); #1;
    check("rst_scl_oen", scl_oen, 1'b1);
    check("rst_sda_oen", sda_oen, 1'b1);
    check("rst_ack", bus.wb_ack_o, 1'b0);
    check("rst_inta", bus.wb_inta_o, 1'b0);
    check("rst_dat_o", bus.wb_dat_o, 8'h00);
    check("scl_pad_o", scl_o, 1'b0);
    check("sda_pad_o", sda_o, 1'b0);
    @(negedge clk) arst_n = 1'b1;

    // PRER write with handshake timing
    @(negedge clk);
    bus.wb_adr_i = 3'd0; bus.wb_dat_i = 8'h02; bus.wb_we_i = 1'b1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    check("ack_before", bus.wb_ack_o, 1'b0);
    @(posedge clk); #1;
    check("ack_rise", bus.wb_ack_o, 1'b1);
    @(posedge clk); #1;
    check("ack_fall", bus.wb_ack_o, 1'b0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    wb_rd(3'd0, r); check("prer_rd", r, 8'h02);

    // unmapped addresses and CTR reserved bits
    wb_wr(3'd5, 8'hFF);
    wb_rd(3'd5, r); check("adr5_rd", r, 8'h00);
    wb_rd(3'd0, r); check("prer_kept", r, 8'h02);
    wb_wr(3'd1, 8'h3F);
    wb_rd(3'd1, r); check("ctr_resv", r, 8'h00);
    wb_wr(3'd1, 8'h80);
    wb_wr(3'd2, 8'h90);
    wb_rd(3'd1, r); check("ctr_rd", r, 8'h80);
    wb_rd(3'd3, r); check("sr_idle", r, 8'h00);

    // START + write 0x90, slave ACKs; CR write during transfer ignored
    clr_mon(); slave_rd = 1'b0; ack_val = 1'b0;
    wb_wr(3'd3, 8'h90);
    wb_rd(3'd3, r); check("sr_tip", r, 8'h02);
    wb_wr(3'd3, 8'h40);
    wait_done("wr1");
    check("wr1_byte", line_byte(), 8'h90);
    check("wr1_ack_line", line_bits[9], 1'b0);
    check("wr1_period", t2 - t1, 12);
    check("wr1_starts", start_cnt, 1);
    check("wr1_stops", stop_cnt, 0);
    wb_rd(3'd3, r); check("wr1_sr", r, 8'h41);

    // interrupt enable and IACK
    wb_wr(3'd1, 8'hC0);
    @(posedge clk); #1;
    check("inta_set", bus.wb_inta_o, 1'b1);
    wb_wr(3'd3, 8'h01);
    @(posedge clk); #1;
    check("inta_iack", bus.wb_inta_o, 1'b0);
    wb_rd(3'd3, r); check("sr_after_iack", r, 8'h40);

    // write with NACK then STOP
    clr_mon(); ack_val = 1'b1;
    wb_wr(3'd3, 8'h50);
    wait_done("wr2");
    check("wr2_byte", line_byte(), 8'h90);
    check("wr2_nack_line", line_bits[9], 1'b1);
    check("wr2_stops", stop_cnt, 1);
    check("wr2_starts", start_cnt, 0);
    wb_rd(3'd3, r); check("wr2_sr", r, 8'h81);
    check("wr2_inta", bus.wb_inta_o, 1'b1);
    wb_wr(3'd3, 8'h01);
    @(posedge clk); #1;
    check("wr2_inta_iack", bus.wb_inta_o, 1'b0);

    // read 0xA5 with NACK from master
    clr_mon(); slave_rd = 1'b1; rd_byte = 8'hA5;
    wb_wr(3'd3, 8'h28);
    wait_done("rd");
    wb_rd(3'd2, r); check("rxr", r, 8'hA5);
    check("rd_line_byte", line_byte(), 8'hA5);
    check("rd_ninth_line", line_bits[9], 1'b1);
    check("rd_ninth_oen", oen9, 1'b1);
    wb_rd(3'd3, r); check("rd_sr", r, 8'h81);
    wb_wr(3'd3, 8'h01);

    // asynchronous reset mid-byte
    clr_mon(); slave_rd = 1'b0; ack_val = 1'b0;
    wb_wr(3'd3, 8'h90);
    repeat (16) @(posedge clk);
    wb_rd(3'd3, r); check("abort_sr_pre", r, 8'hC2);
    for (int k = 0; k < 50; k++) begin
      if (scl_oen == 1'b0) break;
      @(posedge clk); #1;
    end
    check("abort_scl_low", scl_oen, 1'b0);
    @(negedge clk); arst_n = 1'b0; #1;
    check("abort_scl_oen", scl_oen, 1'b1);
    check("abort_sda_oen", sda_oen, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    wb_rd(3'd3, r); check("abort_sr", r, 8'h00);
    wb_rd(3'd0, r); check("abort_prer", r, 8'h00);

    // clean restart
    wb_wr(3'd0, 8'h02);
    wb_wr(3'd1, 8'h80);
    wb_wr(3'd2, 8'h3C);
    clr_mon();
    wb_wr(3'd3, 8'h90);
    wait_done("wr3");
    check("wr3_byte", line_byte(), 8'h3C);
    check("wr3_starts", start_cnt, 1);
    wb_rd(3'd3, r); check("wr3_sr", r, 8'h41);

    // synchronous reset
    @(negedge clk) wb_rst = 1'b1;
    @(posedge clk); #1;
    check("srst_scl_oen", scl_oen, 1'b1);
    check("srst_sda_oen", sda_oen, 1'b1);
    @(negedge clk) wb_rst = 1'b0;
    wb_rd(3'd3, r); check("srst_sr", r, 8'h00);
    wb_rd(3'd1, r); check("srst_ctr", r, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
